// File: rtl/arith_pkg.sv
// Shared arithmetic types and helpers for the bit-serial subtractor.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Counter must hold 0..WIDTH, hence one bit beyond clog2.
    function automatic int unsigned cnt_width(input int unsigned w);
        return int'($clog2(w)) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bin,
        input  diff, bout, ovf, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output diff, bout, ovf, busy, done
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor cell.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_subtractor_if.slave    bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    sub_state_t       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic fs_d_c;
    logic fs_bout_c;

    full_subtractor u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (fs_d_c),
        .bout (fs_bout_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
                    state_d  = RUN;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d    = {fs_d_c, res_q[WIDTH-1:1]};
                borrow_d = fs_bout_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last bit: publish result; fs_d_c is the result sign bit.
                    state_d = DONE;
                    done_d  = 1'b1;
                    diff_d  = {fs_d_c, res_q[WIDTH-1:1]};
                    bout_d  = fs_bout_c;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (fs_d_c ^ a_msb_q);
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed operations, monitor checks results and timing.
module tb_serial_subtractor;
    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic [W-1:0] held_diff;
        logic         held_bout;
        logic         held_ovf;
        int           busy_cnt;
        exp_t         e;
        held_diff = '0;
        held_bout = 1'b0;
        held_ovf  = 1'b0;
        busy_cnt  = 0;
        cyc       = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                chk("rst_diff", 32'(bus.diff), 32'h0);
                chk("rst_bout", 32'(bus.bout), 32'h0);
                chk("rst_ovf",  32'(bus.ovf),  32'h0);
                chk("rst_busy", 32'(bus.busy), 32'h0);
                chk("rst_done", 32'(bus.done), 32'h0);
                held_diff = '0;
                held_bout = 1'b0;
                held_ovf  = 1'b0;
                busy_cnt  = 0;
            end else if (bus.done) begin
                chk("busy_with_done", 32'(bus.busy), 32'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("diff",       32'(bus.diff), 32'(e.diff));
                    chk("bout",       32'(bus.bout), 32'(e.bout));
                    chk("ovf",        32'(bus.ovf),  32'(e.ovf));
                    chk("done_cycle", 32'(cyc),      32'(e.cyc));
                    chk("busy_len",   32'(busy_cnt), 32'(W));
                    held_diff = e.diff;
                    held_bout = e.bout;
                    held_ovf  = e.ovf;
                end
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                chk("hold_diff", 32'(bus.diff), 32'(held_diff));
                chk("hold_bout", 32'(bus.bout), 32'(held_bout));
                chk("hold_ovf",  32'(bus.ovf),  32'(held_ovf));
            end
        end
    end

    // Drive one start at the current negedge and queue its expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bi;
        e.diff = ed;
        e.bout = eb;
        e.ovf  = eo;
        e.cyc  = cyc + 1 + int'(W);
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'hA5;
        bus.b     = 8'h5A;
        bus.bin   = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0); drain();
        issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0); drain();
        issue(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0); drain();
        issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1); drain();
        issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1); drain();
        issue(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1); drain();

        // Start pulse during RUN must be ignored.
        issue(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Back-to-back: new start presented in the DONE cycle.
        issue(8'h44, 8'h04, 1'b0, 8'h40, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        chk("wait_done", 32'(bus.done), 32'h1);
        issue(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0);
        drain();

        // Abort in the middle of RUN: no done, outputs return to reset values.
        bus.start = 1'b1;
        bus.a     = 8'h77;
        bus.b     = 8'h11;
        bus.bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_abort", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_diff", 32'(bus.diff), 32'h0);
        repeat (W + 4) @(negedge clk);
        issue(8'h05, 8'h09, 1'b1, 8'hFB, 1'b1, 1'b0); drain();

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
